// File: rtl/md_sched.sv
// Multi-cycle multiply/divide controller for the EX stage: owns HI/LO, sequences
// mult/multu/div/divu over a fixed cycle count and stalls md instructions while busy.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdOut
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_count, w_count_nxt;
  logic [31:0]   r_a, r_b, r_hi, r_lo;
  logic          r_is_div, r_is_signed;

  logic          w_is_md, w_issue_ok, w_start, w_mthi, w_mtlo, w_done;
  logic [63:0]   w_ext_a, w_ext_b, w_prod;
  logic          w_neg_a, w_neg_b;
  logic [31:0]   w_mag_a, w_mag_b, w_div_b, w_q_mag, w_r_mag, w_quo, w_rem;

  assign w_is_md    = (op >= 4'd1) && (op <= 4'd8);
  assign busy       = (r_state == S_RUN);
  assign stall      = busy && w_is_md;
  // A flushed instruction (req) must leave no trace, so it never issues.
  assign w_issue_ok = (r_state == S_IDLE) && !req && !stall;
  assign w_start    = w_issue_ok && (op >= 4'd1) && (op <= 4'd4);
  assign w_mthi     = w_issue_ok && (op == 4'd5);
  assign w_mtlo     = w_issue_ok && (op == 4'd6);
  assign w_done     = (r_state == S_RUN) && (r_count == CW'(1));

  assign hi    = r_hi;
  assign lo    = r_lo;
  assign mdOut = (op == 4'd7) ? r_hi : (op == 4'd8) ? r_lo : 32'd0;

  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    case (r_state)
      S_IDLE: if (w_start) begin
        w_state_nxt = S_RUN;
        w_count_nxt = (op >= 4'd3) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end
      S_RUN: begin
        if (w_done) begin
          w_state_nxt = S_IDLE;
          w_count_nxt = '0;
        end else begin
          w_count_nxt = r_count - CW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // One 64x64 multiplier serves both mult and multu via sign- or zero-extension.
  assign w_ext_a = r_is_signed ? {{32{r_a[31]}}, r_a} : {32'd0, r_a};
  assign w_ext_b = r_is_signed ? {{32{r_b[31]}}, r_b} : {32'd0, r_b};
  assign w_prod  = w_ext_a * w_ext_b;

  // Signed divide on magnitudes: quotient negated when signs differ, remainder follows the dividend.
  assign w_neg_a = r_is_signed && r_a[31];
  assign w_neg_b = r_is_signed && r_b[31];
  assign w_mag_a = w_neg_a ? (32'd0 - r_a) : r_a;
  assign w_mag_b = w_neg_b ? (32'd0 - r_b) : r_b;
  assign w_div_b = (r_b == 32'd0) ? 32'd1 : w_mag_b;
  assign w_q_mag = w_mag_a / w_div_b;
  assign w_r_mag = w_mag_a % w_div_b;
  assign w_quo   = (w_neg_a ^ w_neg_b) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_rem   = w_neg_a ? (32'd0 - w_r_mag) : w_r_mag;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  // NOTE: the operand latches are reset too, so a reset mid-operation leaves nothing stale behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a         <= '0;
      r_b         <= '0;
      r_is_div    <= 1'b0;
      r_is_signed <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
    end else begin
      if (w_start) begin
        r_a         <= a;
        r_b         <= b;
        r_is_div    <= (op >= 4'd3);
        r_is_signed <= (op == 4'd1) || (op == 4'd3);
      end
      if (w_mthi) r_hi <= a;
      if (w_mtlo) r_lo <= a;
      if (w_done) begin
        if (!r_is_div) begin
          r_hi <= w_prod[63:32];
          r_lo <= w_prod[31:0];
        end else if (r_b != 32'd0) begin
          r_hi <= w_rem;
          r_lo <= w_quo;
        end
      end
    end
  end

endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Multi-cycle multiply/divide controller that sits beside the ALU in the EX stage.
- Owns the HI/LO registers and sequences mult/multu/div/divu over a fixed number of cycles.
- Drives the stall that holds EX/ID while HI/LO are in flight.
- Squashes newly issued HI/LO-side effects when the exception request (req) flushes the pipeline. Its mdOut result travels down the EX/MEM register alongside aluOut.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1).
- DIV_CYCLES, 10, busy cycles for div/divu (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- req  input  1  exception/interrupt flush; instruction currently in EX must not take effect.
- op  input  4  EX-stage md opcode: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, others = none.
- a  input  32  rs operand (forwarded).
- b  input  32  rt operand (forwarded).
- busy  output  1  operation in flight.
- stall  output  1  hold PC/IF-ID/ID-EX, bubble into EX/MEM.
- hi  output  32  HI register.
- lo  output  32  LO register.
- mdOut  output  32  HI for op=7, LO for op=8, else 0 (combinational).

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, count=0, busy=0, hi=0, lo=0, internal operand/result latches=0.
  - A reset in mid-operation abandons the operation; no HI/LO write follows after reset is released.
- States:
  - IDLE: busy=0.
  - RUN: busy=1. count counts down. kind register records mul/div and signedness.
- Start (IDLE, op in 1..4, req=0, stall=0):
  - Latch a, b and op at the edge.
  - Go to RUN with count=MULT_CYCLES or DIV_CYCLES.
  - busy rises the cycle after the start cycle. The start cycle itself does not stall.
- RUN:
  - count decrements each edge.
  - On the edge where count==1: write hi/lo, go to IDLE, busy=0.
  - Net latency: busy high for exactly N cycles; new hi/lo visible the cycle after busy falls.
- Arithmetic, from latched operands:
  - mult: {hi,lo} = signed 64-bit product.
  - multu: {hi,lo} = unsigned 64-bit product.
  - div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - Divide by zero: hi/lo unchanged, full DIV_CYCLES still spent.
  - div with a=32'h80000000, b=32'hFFFFFFFF: lo=32'h80000000, hi=0.
- mthi/mtlo (IDLE, req=0, stall=0): write a into hi/lo at that edge, single cycle.
- mfhi/mflo: mdOut reads the current register. Issuing them in IDLE gives the last committed value.
- Stall: stall = busy && (op in 1..8). No stall in IDLE. Non-md instructions never stall and continue past a busy unit.
- req:
  - While req=1, a start or mthi/mtlo in the same cycle is ignored (no state or HI/LO change).
  - An operation already in RUN is not cancelled. It was issued by an older, committing instruction, so it completes and writes HI/LO.
  - If req and the completion edge coincide, the completion write still happens.
- A new md op arriving in the same cycle as the completion edge sees busy=1 and stalls one cycle. It proceeds the next cycle, seeing the updated hi/lo.
- op values outside 1..8 behave as none.

Test Plan:
- Reset, then op=1, a=32'hFFFFFFFE (-2), b=3 → busy high 5 cycles; then hi=32'hFFFFFFFF, lo=32'hFFFFFFFA; stall=0 throughout (op returns to 0).
- op=4, a=7, b=2, then op=8 held next cycle → stall=1 for 10 cycles, then mdOut=3; later op=7 → mdOut=1.
- op=3, a=-7 (32'hFFFFFFF9), b=2 → lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; op=3, b=0 with prior hi=5, lo=6 → hi/lo stay 5/6 after 10 cycles.
- op=1 with req=1 in the same cycle → busy stays 0, hi/lo unchanged; op=5, a=32'h1234 with req=1 → hi unchanged; repeat with req=0 → hi=32'h1234 next cycle.
- Start op=2, a=b=32'hFFFFFFFF, assert req on cycle 3 of busy → operation completes; hi=32'hFFFFFFFE, lo=1.
- Start op=3, pull reset low at busy cycle 4 → hi=lo=0 and busy=0 immediately; no write after release.
